// File: rtl/fir_pkg.sv
// Shared definitions for the time-multiplexed FIR family: FSM state
// encoding, accumulator sizing and a saturation helper.
package fir_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  // Full-precision accumulator width: product width plus growth for TAPS terms.
  function automatic int fir_acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Clamp a signed value (up to 64 bits) to the signed range of out_w bits.
  function automatic logic signed [63:0] fir_sat(input logic signed [63:0] v, input int out_w);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (out_w - 1));
    if (v > max_v)      return max_v;
    else if (v < min_v) return min_v;
    else                return v;
  endfunction

endpackage

// File: rtl/fir_tdm_mac.sv
// Signed multiply-accumulate with synchronous clear and enable.
// Clear has priority over enable; the product is sign-extended to ACC_W.
module fir_mac #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 35
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [COEF_W-1:0] coef_i,
  input  logic signed [DATA_W-1:0] data_i,
  output logic signed [ACC_W-1:0]  acc_o
);

  logic signed [DATA_W+COEF_W-1:0] prod;
  logic signed [ACC_W-1:0]         acc_q;
  logic signed [ACC_W-1:0]         acc_d;

  assign prod  = coef_i * data_i;
  assign acc_o = acc_q;

  // Next accumulator value: clear, accumulate or hold.
  always_comb begin
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = acc_q + ACC_W'(prod);
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/fir_tdm.sv
// Time-multiplexed direct-form FIR filter with one shared MAC.
// Flow: IDLE accepts a sample and shifts the delay line, MAC spends TAPS
// cycles accumulating c[i]*d[i], OUT presents the result until taken.
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; the source holds its data stable while valid is high and ready
// is low, and out_data/out_valid stay stable until out_ready is seen.
// Optional macro FIR_SAT_EN: saturate out_data to the OUT_W signed range
// and add the sat_flag output; otherwise out_data wraps.
module fir_tdm
  import fir_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int COEF_W  = 16,
  parameter int TAPS    = 8,
  parameter int OUT_W   = 32,
  localparam int ACC_W  = fir_acc_width(DATA_W, COEF_W, TAPS),
  localparam int AW     = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_data,
`ifdef FIR_SAT_EN
  output logic                     sat_flag,
`endif
  output logic                     busy
);

  localparam logic [AW-1:0] IDX_LAST = AW'(TAPS - 1);

  logic [1:0]               state_q, state_d;
  logic [AW-1:0]            idx_q, idx_d;
  logic signed [DATA_W-1:0] dly_q  [TAPS];
  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic                     accept;
  logic                     coef_ok;

  assign in_ready  = (state_q == ST_IDLE) && !reset;
  assign out_valid = (state_q == ST_OUT);
  assign busy      = (state_q != ST_IDLE);
  assign accept    = in_valid && (state_q == ST_IDLE);
  // Writes outside IDLE are dropped so a pass never mixes coefficient sets.
  assign coef_ok   = coef_we && (state_q == ST_IDLE) &&
                     ({1'b0, coef_addr} < (AW+1)'(TAPS));

  // FSM next state and tap index.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_MAC;
          idx_d   = '0;
        end
      end
      ST_MAC: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = ST_OUT;
          idx_d   = '0;
        end
      end
      ST_OUT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and tap index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Delay line shift on accept; coefficient RAM write in IDLE only.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) begin
        dly_q[k]  <= '0;
        coef_q[k] <= '0;
      end
    end else begin
      if (accept) begin
        dly_q[0] <= in_data;
        for (int k = 1; k < TAPS; k++) dly_q[k] <= dly_q[k-1];
      end
      if (coef_ok) coef_q[coef_addr] <= coef_data;
    end
  end

  fir_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (accept),
    .en_i   (state_q == ST_MAC),
    .coef_i (coef_q[idx_q]),
    .data_i (dly_q[idx_q]),
    .acc_o  (acc)
  );

`ifdef FIR_SAT_EN
  logic signed [63:0] acc_ext;
  logic signed [63:0] acc_sat;

  // Clamp the accumulator to the output range and flag any clamping.
  always_comb begin
    acc_ext = 64'(acc);
    acc_sat = fir_sat(acc_ext, OUT_W);
  end

  assign out_data = OUT_W'(acc_sat);
  assign sat_flag = out_valid && (acc_sat != acc_ext);
`else
  // Signed size cast: truncates (wraps) when narrower, sign-extends when wider.
  assign out_data = OUT_W'(acc);
`endif

endmodule

// File: tb/tb_fir_tdm.sv
// Self-checking bench for fir_tdm: directed impulse/step/backpressure/
// coefficient-write/reset cases plus randomized passes, all checked against
// a sum-of-products reference model. Define FIR_SAT_EN to test saturation.
`timescale 1ns/1ps
module tb_fir_tdm;

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int TAPS   = 8;
  localparam int OUT_W  = 32;
  localparam int AW     = $clog2(TAPS);

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data = '0;
  logic                     coef_we = 1'b0;
  logic [AW-1:0]            coef_addr = '0;
  logic signed [COEF_W-1:0] coef_data = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic signed [OUT_W-1:0]  out_data;
  logic                     busy;
`ifdef FIR_SAT_EN
  logic                     sat_flag;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [OUT_W-1:0] exp_q[$];
  logic             exp_sat_q[$];
  longint           m_c [TAPS];
  longint           m_d [TAPS];

  fir_tdm #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .TAPS   (TAPS),
    .OUT_W  (OUT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef FIR_SAT_EN
    .sat_flag  (sat_flag),
`endif
    .busy      (busy)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_clear();
    for (int k = 0; k < TAPS; k++) begin
      m_c[k] = 0;
      m_d[k] = 0;
    end
    exp_q.delete();
    exp_sat_q.delete();
  endtask

  // New sample enters the history; expected output is the plain dot product,
  // then either clamped or wrapped to OUT_W bits.
  task automatic model_accept(input longint x);
    longint     s;
    logic [63:0] s64;
    longint     max_v;
    longint     min_v;
    for (int k = TAPS - 1; k > 0; k--) m_d[k] = m_d[k-1];
    m_d[0] = x;
    s = 0;
    for (int k = 0; k < TAPS; k++) s += m_c[k] * m_d[k];
    max_v = (longint'(1) << (OUT_W - 1)) - 1;
    min_v = -(longint'(1) << (OUT_W - 1));
`ifdef FIR_SAT_EN
    if (s > max_v) begin s64 = max_v; exp_sat_q.push_back(1'b1); end
    else if (s < min_v) begin s64 = min_v; exp_sat_q.push_back(1'b1); end
    else begin s64 = s; exp_sat_q.push_back(1'b0); end
`else
    s64 = s;
    exp_sat_q.push_back((s > max_v) || (s < min_v));
`endif
    exp_q.push_back(s64[OUT_W-1:0]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_coef(input int a, input longint v);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = AW'(a);
    coef_data = COEF_W'(v);
    @(posedge clk);
    #1;
    coef_we = 1'b0;
    m_c[a] = v;
  endtask

  task automatic load_coefs(input longint c0, input longint c1, input longint c2,
                            input longint c3, input longint rest);
    write_coef(0, c0);
    write_coef(1, c1);
    write_coef(2, c2);
    write_coef(3, c3);
    for (int k = 4; k < TAPS; k++) write_coef(k, rest);
  endtask

  // One full pass: offer a sample (optionally with a coincident coefficient
  // write), optionally poke a coefficient mid-pass, hold off the output for
  // `hold` cycles, then take it and compare with the model.
  task automatic send_sample(input longint x, input int hold, input bit mac_wr,
                             input bit co_we, input int co_addr, input longint co_val);
    int n;
    logic [OUT_W-1:0] e;
    logic es;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = DATA_W'(x);
    if (co_we) begin
      coef_we   = 1'b1;
      coef_addr = AW'(co_addr);
      coef_data = COEF_W'(co_val);
    end
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("in_ready_idle", in_ready, 1);
    if (co_we) m_c[co_addr] = co_val;
    model_accept(x);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (mac_wr) begin
        if (n == 3) begin
          coef_we   = 1'b1;
          coef_addr = '0;
          coef_data = COEF_W'(50);
        end else begin
          coef_we = 1'b0;
        end
      end
    end while (!out_valid && n < 40);
    coef_we = 1'b0;
    check_eq("latency", n, TAPS + 1);
    e  = exp_q.pop_front();
    es = exp_sat_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      check_eq("bp_valid", out_valid, 1);
      check_eq("bp_in_ready", in_ready, 0);
      check_eq("bp_data", out_data, $signed(e));
      @(negedge clk);
    end
    out_ready = 1'b1;
    check_eq("out_valid", out_valid, 1);
    check_eq("out_data", out_data, $signed(e));
`ifdef FIR_SAT_EN
    check_eq("sat_flag", sat_flag, es);
`endif
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check_eq("released", out_valid, 0);
    check_eq("idle_busy", busy, 0);
  endtask

  task automatic plain(input longint x);
    send_sample(x, 0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_busy", busy, 0);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    check_eq("post_rst_in_ready", in_ready, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int seen;
    model_clear();
    do_reset();

    // Impulse response.
    load_coefs(1, 2, 3, 4, 0);
    plain(1);
    for (int k = 0; k < 7; k++) plain(0);

    // Step response.
    for (int k = 0; k < 8; k++) plain(100);

    // Backpressure: output held for 5 cycles.
    send_sample(-37, 5, 1'b0, 1'b0, 0, 0);
    send_sample(1234, 2, 1'b0, 1'b0, 0, 0);

    // Coefficient write during MAC is ignored.
    send_sample(7, 0, 1'b1, 1'b0, 0, 0);
    plain(3);
    // Coefficient write coincident with accept takes effect for that sample.
    send_sample(7, 0, 1'b0, 1'b1, 0, 50);
    write_coef(0, 1);
    plain(1);

    // Reset mid-MAC: pass abandoned, history and coefficients cleared.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = DATA_W'(5);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("mid_mac_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_busy", busy, 0);
    reset = 1'b0;
    model_clear();
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_eq("no_out_after_rst", seen, 0);
    plain(1);
    plain(0);

    // Randomized passes with random coefficients, data and backpressure.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < TAPS; k++)
        write_coef(k, longint'($urandom_range(0, 65535)) - 32768);
      for (int s = 0; s < 10; s++)
        send_sample(longint'($urandom_range(0, 65535)) - 32768,
                    int'($urandom_range(0, 3)), 1'b0, 1'b0, 0, 0);
    end

    // Saturation / wrap: full-scale coefficients and data.
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, 32767);
    for (int k = 0; k < 8; k++) plain(32767);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
